// File: rtl/irq_pkg.sv
// ============================================================================
// irq_pkg -- shared types, mode/polarity constants and priority encoder
// Revision: 1.0
// ============================================================================
`default_nettype none

package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_EDGE  = 1'b1;
  localparam logic POL_LOW    = 1'b0;
  localparam logic POL_HIGH   = 1'b1;

  // Lowest set index wins; returns 0 for an all-zero vector.
  function automatic logic [4:0] prio_enc(input logic [31:0] vec);
    logic [4:0] idx;
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/irq_edge_sync.sv
// ============================================================================
// irq_edge_sync -- one channel: synchronizer, history flop, edge/level detect
// Revision: 1.0
// ============================================================================
`default_nettype none

module irq_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic irq_i,
  input  logic pol_i,
  input  logic primed_i,
  output logic edge_o,
  output logic level_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   edge_q;
  logic                   level_q;
  logic                   sync_bit;

  assign sync_bit = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q  <= '0;
      hist_q  <= 1'b0;
      edge_q  <= 1'b0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], irq_i};
      hist_q  <= sync_bit;
      // Edges are masked until the chain has flushed its reset zeros.
      edge_q  <= primed_i && (hist_q != sync_bit) && (sync_bit == pol_i);
      level_q <= (sync_bit == pol_i);
    end
  end

  assign edge_o  = edge_q;
  assign level_o = level_q;

endmodule

`default_nettype wire

// File: rtl/irq_controller.sv
// ============================================================================
// irq_controller -- vectored fixed-priority interrupt controller with
// req/ack/eoi handshake. Define IRQ_NEST_EN for preemptive nesting.
// Revision: 1.0
// ============================================================================
`default_nettype none

module irq_controller
  import irq_pkg::*;
#(
  parameter int NUM_IRQ     = 24,
  parameter int ID_W        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] cfg_enable,
  input  logic [NUM_IRQ-1:0] cfg_edge,
  input  logic [NUM_IRQ-1:0] cfg_pol,
  input  logic               global_en,
  input  logic               irq_ack,
  input  logic               irq_eoi,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_IRQ-1:0] pending_o,
  output logic [NUM_IRQ-1:0] in_service_o
);

  localparam int PRIME_W = 3;

  irq_state_e         state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               req_q, req_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic [PRIME_W-1:0] prime_cnt_q;

  logic               primed;
  logic [NUM_IRQ-1:0] edge_det, level_act;
  logic [NUM_IRQ-1:0] id_oh, ack_clr, isr_low, isr_after, elig;
  logic               eoi_go;
  logic [4:0]         elig_enc;
  logic [ID_W-1:0]    elig_id;

  assign primed = (prime_cnt_q == PRIME_W'(SYNC_STAGES + 1));

  always_ff @(posedge clk) begin
    if (!rst) prime_cnt_q <= '0;
    else if (!primed) prime_cnt_q <= prime_cnt_q + PRIME_W'(1);
  end

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_chan
    irq_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk      (clk),
      .rst      (rst),
      .irq_i    (irq_in[g]),
      .pol_i    (cfg_pol[g]),
      .primed_i (primed),
      .edge_o   (edge_det[g]),
      .level_o  (level_act[g])
    );
  end

  always_comb begin
    id_oh = '0;
    for (int i = 0; i < NUM_IRQ; i++) id_oh[i] = (id_q == ID_W'(i));
  end

`ifdef IRQ_NEST_EN
  assign eoi_go = irq_eoi && ((state_q == SERVICE) || (state_q == REQ));
`else
  assign eoi_go = irq_eoi && (state_q == SERVICE);
`endif

  // Lowest set in_service bit is the innermost (highest-priority) handler.
  assign isr_low   = isr_q & (~isr_q + NUM_IRQ'(1));
  assign isr_after = eoi_go ? (isr_q & ~isr_low) : isr_q;
  assign ack_clr   = (state_q == REQ && irq_ack) ? id_oh : '0;

`ifdef IRQ_NEST_EN
  logic [4:0] isr_top;
  assign isr_top = prio_enc(32'(isr_after));
`endif

  always_comb begin
    elig = '0;
    if (state_q == IDLE) elig = pend_q;
`ifdef IRQ_NEST_EN
    else if (state_q == SERVICE) begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (i < int'(isr_top)) elig[i] = pend_q[i];
      end
    end
`endif
  end

  assign elig_enc = prio_enc(32'(elig));
  assign elig_id  = elig_enc[ID_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      id_q    <= '0;
      req_q   <= 1'b0;
      pend_q  <= '0;
      isr_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      req_q   <= req_d;
      pend_q  <= pend_d;
      isr_q   <= isr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (global_en && |elig) begin
          state_d = REQ;
          id_d    = elig_id;
        end
      end
      REQ: begin
        if (irq_ack) state_d = SERVICE;
      end
      SERVICE: begin
        if (isr_after == '0) state_d = IDLE;
        else if (global_en && |elig) begin
          state_d = REQ;
          id_d    = elig_id;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d  = (state_d == REQ);
    isr_d  = isr_after;
    if (state_q == REQ && irq_ack) isr_d = isr_after | id_oh;
    pend_d = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      // Set wins over an ack clear landing in the same cycle.
      if (cfg_edge[i] == MODE_EDGE)
        pend_d[i] = (pend_q[i] & ~ack_clr[i]) | (edge_det[i] & cfg_enable[i]);
      else
        pend_d[i] = level_act[i] & cfg_enable[i];
    end
  end

  assign irq_req      = req_q;
  assign irq_id       = id_q;
  assign pending_o    = pend_q;
  assign in_service_o = isr_q;

endmodule

`default_nettype wire

// File: tb/tb_irq_controller.sv
// ============================================================================
// tb_irq_controller -- directed stimulus with a transaction-level model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_irq_controller;

  localparam int N   = 24;
  localparam int S   = 2;
  localparam int IDW = 5;
`ifdef IRQ_NEST_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   irq_in, cfg_enable, cfg_edge, cfg_pol;
  logic           global_en, irq_ack, irq_eoi;
  logic           irq_req;
  logic [IDW-1:0] irq_id;
  logic [N-1:0]   pending_o, in_service_o;

  int checks = 0;
  int errors = 0;

  irq_controller #(.NUM_IRQ(N), .ID_W(IDW), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .cfg_enable(cfg_enable),
    .cfg_edge(cfg_edge), .cfg_pol(cfg_pol), .global_en(global_en),
    .irq_ack(irq_ack), .irq_eoi(irq_eoi), .irq_req(irq_req), .irq_id(irq_id),
    .pending_o(pending_o), .in_service_o(in_service_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model: sample history, pending set, service stack -------
  logic [N-1:0] sh [0:S+1];
  int           ecount = 0;
  bit           mvalid = 1'b0;
  logic [N-1:0] m_pend = '0;
  bit           m_req  = 1'b0;
  int           m_id   = 0;
  int           stack[$];

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [N-1:0] stack_bits();
    logic [N-1:0] b = '0;
    foreach (stack[k]) b[stack[k]] = 1'b1;
    return b;
  endfunction

  task automatic model_step();
    logic [N-1:0] old_pend, cand_v;
    bit old_req, edge_ev, clr;
    int old_id, pre_size, mi, mv, cand;
    if (!rst) begin
      mvalid = 1'b1; ecount = 0; m_pend = '0; m_req = 1'b0; m_id = 0;
      stack.delete();
      for (int k = 0; k <= S + 1; k++) sh[k] = '0;
      return;
    end
    if (ecount < 1000) ecount++;
    old_pend = m_pend; old_req = m_req; old_id = m_id; pre_size = stack.size();
    // end of interrupt retires the highest-priority handler in the stack
    if (irq_eoi && pre_size > 0 && (!old_req || NEST)) begin
      mi = 0; mv = stack[0];
      foreach (stack[k]) if (stack[k] < mv) begin mv = stack[k]; mi = k; end
      stack.delete(mi);
    end
    if (old_req && irq_ack) begin
      stack.push_back(old_id);
      m_req = 1'b0;
    end
    if (!old_req && global_en) begin
      cand_v = '0;
      if (pre_size == 0) cand_v = old_pend;
      else if (NEST && stack.size() > 0) begin
        mv = N;
        foreach (stack[k]) if (stack[k] < mv) mv = stack[k];
        for (int i = 0; i < mv; i++) cand_v[i] = old_pend[i];
      end
      cand = lowest(cand_v);
      if (cand >= 0) begin m_req = 1'b1; m_id = cand; end
    end
    for (int i = 0; i < N; i++) begin
      if (cfg_edge[i]) begin
        edge_ev = (ecount >= S + 3) && (sh[S][i] != sh[S+1][i]) && (sh[S][i] == cfg_pol[i]);
        clr     = old_req && irq_ack && (old_id == i);
        m_pend[i] = (old_pend[i] && !clr) || (edge_ev && cfg_enable[i]);
      end else begin
        m_pend[i] = (ecount >= 2) && (sh[S][i] == cfg_pol[i]) && cfg_enable[i];
      end
    end
    for (int k = S + 1; k > 0; k--) sh[k] = sh[k-1];
    sh[0] = irq_in;
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    if (mvalid) begin
      check("model_req", 32'(irq_req), 32'(m_req));
      if (m_req) check("model_id", 32'(irq_id), 32'(m_id));
      check("model_pending", 32'(pending_o), 32'(m_pend));
      check("model_in_service", 32'(in_service_o), 32'(stack_bits()));
    end
  end

  // ---------------- directed stimulus -----------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    irq_eoi = 1'b1; tick(1); irq_eoi = 1'b0;
  endtask

  initial begin
    rst = 1'b0; irq_in = 24'hFFFFF3; cfg_enable = '1;
    cfg_edge = 24'hFFFFF7; cfg_pol = 24'h00000C;
    global_en = 1'b1; irq_ack = 1'b0; irq_eoi = 1'b0;
    tick(3);
    check("rst_req", 32'(irq_req), 32'd0);
    check("rst_id", 32'(irq_id), 32'd0);
    check("rst_pending", 32'(pending_o), 32'd0);
    check("rst_isr", 32'(in_service_o), 32'd0);
    rst = 1'b1;
    tick(6);

    // single falling edge on channel 5
    irq_in[5] = 1'b0;
    tick(4);
    check("s1_req_early", 32'(irq_req), 32'd0);
    check("s1_pend5", 32'(pending_o[5]), 32'd1);
    tick(1);
    check("s1_req", 32'(irq_req), 32'd1);
    check("s1_id", 32'(irq_id), 32'd5);
    pulse_ack();
    check("s1_ack_pend", 32'(pending_o), 32'd0);
    check("s1_ack_isr", 32'(in_service_o), 32'h20);
    check("s1_ack_req", 32'(irq_req), 32'd0);
    irq_in[5] = 1'b1;
    pulse_eoi();
    check("s1_eoi_isr", 32'(in_service_o), 32'd0);

    // simultaneous 5 and 7
    tick(2);
    irq_in[5] = 1'b0; irq_in[7] = 1'b0;
    tick(5);
    check("s2_req", 32'(irq_req), 32'd1);
    check("s2_id5", 32'(irq_id), 32'd5);
    check("s2_pend", 32'(pending_o), 32'hA0);
    pulse_ack();
    pulse_eoi();
    check("s2_idle_gap", 32'(irq_req), 32'd0);
    tick(1);
    check("s2_req7", 32'(irq_req), 32'd1);
    check("s2_id7", 32'(irq_id), 32'd7);
    pulse_ack();
    irq_in[5] = 1'b1; irq_in[7] = 1'b1;
    pulse_eoi();

    // channel 5 fires while 7 is in service
    tick(2);
    irq_in[7] = 1'b0;
    tick(5);
    check("s3_id7", 32'(irq_id), 32'd7);
    pulse_ack();
    check("s3_isr7", 32'(in_service_o), 32'h80);
    irq_in[5] = 1'b0;
    tick(5);
`ifdef IRQ_NEST_EN
    check("s3n_req", 32'(irq_req), 32'd1);
    check("s3n_id5", 32'(irq_id), 32'd5);
    pulse_ack();
    check("s3n_isr_a0", 32'(in_service_o), 32'hA0);
    pulse_eoi();
    check("s3n_isr_80", 32'(in_service_o), 32'h80);
    pulse_eoi();
    check("s3n_isr_0", 32'(in_service_o), 32'd0);
`else
    check("s3_noreq", 32'(irq_req), 32'd0);
    check("s3_pend5", 32'(pending_o[5]), 32'd1);
    tick(3);
    check("s3_noreq2", 32'(irq_req), 32'd0);
    pulse_eoi();
    check("s3_isr0", 32'(in_service_o), 32'd0);
    tick(1);
    check("s3_req5", 32'(irq_req), 32'd1);
    check("s3_id5", 32'(irq_id), 32'd5);
    pulse_ack();
    pulse_eoi();
`endif
    irq_in[5] = 1'b1; irq_in[7] = 1'b1;

    // global enable gating, stray ack/eoi in idle
    tick(2);
    global_en = 1'b0; irq_in[9] = 1'b0;
    tick(6);
    check("ge_noreq", 32'(irq_req), 32'd0);
    check("ge_pend9", 32'(pending_o[9]), 32'd1);
    global_en = 1'b1;
    tick(1);
    check("ge_id9", 32'(irq_id), 32'd9);
    pulse_ack(); pulse_eoi();
    irq_in[9] = 1'b1;
    irq_ack = 1'b1; irq_eoi = 1'b1; tick(1); irq_ack = 1'b0; irq_eoi = 1'b0;
    check("stray_isr", 32'(in_service_o), 32'd0);

    // level-mode channel 3, active high
    tick(2);
    irq_in[3] = 1'b1;
    tick(5);
    check("lv_id3", 32'(irq_id), 32'd3);
    pulse_ack();
    check("lv_pend_kept", 32'(pending_o[3]), 32'd1);
    check("lv_isr", 32'(in_service_o), 32'h08);
    pulse_eoi();
    check("lv_gap", 32'(irq_req), 32'd0);
    tick(1);
    check("lv_rereq", 32'(irq_req), 32'd1);
    check("lv_reid", 32'(irq_id), 32'd3);
    pulse_ack();
    cfg_enable[3] = 1'b0;
    tick(1);
    check("lv_disabled", 32'(pending_o[3]), 32'd0);
    irq_in[3] = 1'b0;
    pulse_eoi();
    tick(6);
    cfg_enable[3] = 1'b1;
    tick(2);

    // channel 2 rising input held through reset, then reset mid-request
    irq_in[2] = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(8);
    check("s5_no_false_edge", 32'(pending_o[2]), 32'd0);
    irq_in[2] = 1'b0;
    tick(4);
    irq_in[2] = 1'b1;
    tick(4);
    check("s5_pend2", 32'(pending_o[2]), 32'd1);
    tick(1);
    check("s5_id2", 32'(irq_id), 32'd2);
    rst = 1'b0;
    tick(1);
    check("s5_rst_req", 32'(irq_req), 32'd0);
    check("s5_rst_id", 32'(irq_id), 32'd0);
    check("s5_rst_pend", 32'(pending_o), 32'd0);
    check("s5_rst_isr", 32'(in_service_o), 32'd0);
    rst = 1'b1;
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
